cache: RTL and testbench

// - Direct-mapped, write-back cache data/tag store with 16 lines of 4 x 16-bit words and a 5-bit tag.
// - Performs one access per enabled clock and flags completion on ack.
// - Sits between a requester and the cache controller FSM. The controller issues compare and access

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_array.sv | 52 +++++
 rtl/cache.sv | 100 ++++++++++
 tb/tb_cache.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths and command encoding for the direct-mapped cache data/tag store.
package cache_pkg;

    localparam int DATA_W  = 16;
    localparam int TAG_W   = 5;
    localparam int INDEX_W = 4;
    localparam int WORD_W  = 2;

    // Encoded as {cmp, write} so the request pins cast straight onto it.
    typedef enum logic [1:0] {
        ACC_RD = 2'b00,
        ACC_WR = 2'b01,
        CMP_RD = 2'b10,
        CMP_WR = 2'b11
    } cache_cmd_e;

endpackage

// File: rtl/cache_array.sv
// Per-line tag/valid/dirty registers plus word storage; one synchronous write
// port and a combinational read of the addressed line/word.
module cache_array
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [INDEX_W-1:0] index,
    input  logic [WORD_W-1:0] word,
    input  logic [TAG_W-1:0]  wtag,
    input  logic              wvalid,
    input  logic              wdirty,
    input  logic [DATA_W-1:0] wdata,
    output logic [TAG_W-1:0]  rtag,
    output logic              rvalid,
    output logic              rdirty,
    output logic [DATA_W-1:0] rdata
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << WORD_W;

    logic [TAG_W-1:0]  tag_q   [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [DATA_W-1:0] data_q  [LINES][WORDS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int l = 0; l < LINES; l++) begin
                tag_q[l] <= '0;
                for (int w = 0; w < WORDS; w++) begin
                    data_q[l][w] <= '0;
                end
            end
        end else if (we) begin
            tag_q[index]         <= wtag;
            valid_q[index]       <= wvalid;
            dirty_q[index]       <= wdirty;
            data_q[index][word]  <= wdata;
        end
    end

    assign rtag   = tag_q[index];
    assign rvalid = valid_q[index];
    assign rdirty = dirty_q[index];
    assign rdata  = data_q[index][word];

endmodule

// File: rtl/cache.sv
// Direct-mapped write-back cache store: command decode, tag match and the
// registered response (hit/dirty/tag_out/data_out/valid/ack).
module cache
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [INDEX_W-1:0] index,
    input  logic [WORD_W-1:0]  word,
    input  logic               cmp,
    input  logic               write,
    input  logic [TAG_W-1:0]   tag,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               valid_in,
    output logic               hit,
    output logic               dirty,
    output logic [TAG_W-1:0]   tag_out,
    output logic [DATA_W-1:0]  data_out,
    output logic               valid,
    output logic               ack
);

    // Handshake: a request is taken on every rising edge with enable=1 and
    // rst=1; ack is high for the cycle after each taken request, so it stays
    // high across back-to-back requests and the other outputs hold otherwise.

    cache_cmd_e        cmd;
    logic              match;
    logic              we;
    logic [TAG_W-1:0]  wtag;
    logic              wvalid;
    logic [TAG_W-1:0]  rtag;
    logic              rvalid;
    logic              rdirty;
    logic [DATA_W-1:0] rdata;

    assign cmd   = cache_cmd_e'({cmp, write});
    assign match = rvalid && (rtag == tag);

    // Compare-write rewrites the existing tag/valid so only the word and dirty change.
    assign we     = rst && enable && ((cmd == ACC_WR) || ((cmd == CMP_WR) && match));
    assign wtag   = (cmd == ACC_WR) ? tag      : rtag;
    assign wvalid = (cmd == ACC_WR) ? valid_in : rvalid;

    cache_array u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .index  (index),
        .word   (word),
        .wtag   (wtag),
        .wvalid (wvalid),
        .wdirty (cmd == CMP_WR),
        .wdata  (data_in),
        .rtag   (rtag),
        .rvalid (rvalid),
        .rdirty (rdirty),
        .rdata  (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit      <= 1'b0;
            dirty    <= 1'b0;
            tag_out  <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            ack      <= 1'b0;
        end else if (enable) begin
            ack <= 1'b1;
            case (cmd)
                CMP_RD, CMP_WR: begin
                    hit      <= match;
                    tag_out  <= rtag;
                    valid    <= rvalid;
                    data_out <= rdata;
                    dirty    <= (cmd == CMP_WR && match) ? 1'b1 : rdirty;
                end
                ACC_RD: begin
                    hit      <= 1'b0;
                    tag_out  <= rtag;
                    valid    <= rvalid;
                    data_out <= rdata;
                    dirty    <= rdirty;
                end
                default: begin
                    hit      <= 1'b0;
                    tag_out  <= tag;
                    valid    <= valid_in;
                    data_out <= data_in;
                    dirty    <= 1'b0;
                end
            endcase
        end else begin
            ack <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: behavioural line/word model feeding an expected
// queue checked every cycle, plus hand-computed literal checks.
module tb_cache;
    import cache_pkg::*;

    localparam int EXP_W = 4 + TAG_W + DATA_W;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               enable = 1'b0;
    logic [INDEX_W-1:0] index = '0;
    logic [WORD_W-1:0]  word = '0;
    logic               cmp = 1'b0;
    logic               write = 1'b0;
    logic [TAG_W-1:0]   tag = '0;
    logic [DATA_W-1:0]  data_in = '0;
    logic               valid_in = 1'b0;
    logic               hit, dirty, valid, ack;
    logic [TAG_W-1:0]   tag_out;
    logic [DATA_W-1:0]  data_out;

    int tests = 0;
    int fails = 0;

    cache dut (
        .clk(clk), .rst(rst), .enable(enable), .index(index), .word(word),
        .cmp(cmp), .write(write), .tag(tag), .data_in(data_in), .valid_in(valid_in),
        .hit(hit), .dirty(dirty), .tag_out(tag_out), .data_out(data_out),
        .valid(valid), .ack(ack)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // behavioural model: memory arrays and last response
    logic [TAG_W-1:0]  m_tag   [16];
    logic              m_val   [16];
    logic              m_dirty [16];
    logic [DATA_W-1:0] m_data  [16][4];
    logic              e_ack, e_hit, e_dirty, e_valid;
    logic [TAG_W-1:0]  e_tag;
    logic [DATA_W-1:0] e_data;

    logic [EXP_W-1:0] exp_q[$];

    task automatic model_step();
        logic m;
        if (!rst) begin
            for (int l = 0; l < 16; l++) begin
                m_tag[l] = '0; m_val[l] = 1'b0; m_dirty[l] = 1'b0;
                for (int w = 0; w < 4; w++) m_data[l][w] = '0;
            end
            {e_ack, e_hit, e_dirty, e_valid, e_tag, e_data} = '0;
        end else if (!enable) begin
            e_ack = 1'b0;
        end else begin
            e_ack = 1'b1;
            m = m_val[index] && (m_tag[index] == tag);
            if (cmp) begin
                e_hit   = m;
                e_tag   = m_tag[index];
                e_valid = m_val[index];
                e_data  = m_data[index][word];
                if (write && m) begin
                    m_data[index][word] = data_in;
                    m_dirty[index] = 1'b1;
                end
                e_dirty = m_dirty[index];
            end else begin
                if (write) begin
                    m_tag[index] = tag;
                    m_val[index] = valid_in;
                    m_dirty[index] = 1'b0;
                    m_data[index][word] = data_in;
                end
                e_hit   = 1'b0;
                e_tag   = m_tag[index];
                e_valid = m_val[index];
                e_dirty = m_dirty[index];
                e_data  = m_data[index][word];
            end
        end
        exp_q.push_back({e_ack, e_hit, e_dirty, e_valid, e_tag, e_data});
    endtask

    // scoreboard: one comparison per cycle that has an expectation queued
    initial begin
        logic [EXP_W-1:0] ev;
        logic [EXP_W-1:0] av;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                av = {ack, hit, dirty, valid, tag_out, data_out};
                tests++;
                if (av !== ev) begin
                    fails++;
                    $display("FAIL cycle_cmp t=%0t {ack,hit,dirty,valid,tag,data} got %h expected %h",
                             $time, av, ev);
                end
            end
        end
    end

    // driver tasks
    task automatic do_op(input logic r, input logic en, input logic c, input logic w,
                         input int idx, input int wd, input int tg, input int d,
                         input logic vin);
        @(negedge clk);
        rst      = r;
        enable   = en;
        cmp      = c;
        write    = w;
        index    = INDEX_W'(idx);
        word     = WORD_W'(wd);
        tag      = TAG_W'(tg);
        data_in  = DATA_W'(d);
        valid_in = vin;
        model_step();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, got, expv);
        end
    endtask

    initial begin
        // reset
        do_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("reset_ack", int'(ack), 0);
        check("reset_outs", int'({hit, dirty, valid, tag_out, data_out}), 0);

        // access-write index 0 word 3
        do_op(1, 1, 0, 1, 0, 3, 5'b11101, 16'h0F0F, 1);
        settle();
        check("accwr_ack", int'(ack), 1);
        check("accwr_tag", int'(tag_out), 5'b11101);
        check("accwr_vdh", int'({valid, dirty, hit}), 3'b100);

        // compare-read hit
        do_op(1, 1, 1, 0, 0, 3, 5'b11101, 0, 0);
        settle();
        check("cmprd_hit", int'(hit), 1);
        check("cmprd_data", int'(data_out), 16'h0F0F);

        // compare-read miss on tag
        do_op(1, 1, 1, 0, 0, 3, 5'b00001, 0, 0);
        settle();
        check("cmprd_miss_hit", int'(hit), 0);
        check("cmprd_miss_tag", int'(tag_out), 5'b11101);

        // compare-write hit, then access-read
        do_op(1, 1, 1, 1, 0, 1, 5'b11101, 16'hBEEF, 0);
        settle();
        check("cmpwr_hit_dirty", int'({hit, dirty}), 2'b11);
        do_op(1, 1, 0, 0, 0, 1, 0, 0, 0);
        settle();
        check("accrd_data", int'(data_out), 16'hBEEF);
        check("accrd_dirty", int'(dirty), 1);

        // reset with enable high, then compare-read
        do_op(0, 1, 1, 0, 0, 3, 5'b11101, 0, 0);
        settle();
        check("rst_en_ack", int'(ack), 0);
        do_op(1, 1, 1, 0, 0, 3, 5'b11101, 0, 0);
        settle();
        check("post_rst_cmp", int'({hit, valid, dirty, data_out}), 0);

        // enable low: ack drops, outputs hold
        do_op(1, 1, 0, 1, 2, 2, 5'b01010, 16'h5A5A, 1);
        do_op(1, 0, 0, 0, 7, 0, 0, 0, 0);
        do_op(1, 0, 1, 1, 7, 0, 3, 16'hFFFF, 1);
        settle();
        check("idle_ack", int'(ack), 0);
        check("idle_hold", int'({valid, tag_out, data_out}), {1'b1, 5'b01010, 16'h5A5A});

        // compare-write to an invalid line (tag matches stored 0) must not write
        do_op(1, 1, 1, 1, 5, 0, 0, 16'h1234, 0);
        settle();
        check("cmpwr_inv_hit", int'(hit), 0);
        do_op(1, 1, 0, 0, 5, 0, 0, 0, 0);
        settle();
        check("cmpwr_inv_line", int'({valid, dirty, data_out}), 0);

        // fill every line back-to-back, then read them all with compare
        for (int i = 0; i < 16; i++)
            do_op(1, 1, 0, 1, i, i % 4, i + 3, i * 16'h1111 + 16'h0A05, i % 2);
        for (int i = 0; i < 16; i++)
            do_op(1, 1, 1, 0, i, i % 4, i + 3, 0, 0);
        // back-to-back write then read of the same line
        do_op(1, 1, 1, 1, 15, 3, 18, 16'hC0DE, 0);
        do_op(1, 1, 1, 0, 15, 3, 18, 0, 0);
        do_op(1, 1, 1, 1, 15, 0, 7, 16'hDEAD, 0);
        do_op(1, 1, 0, 0, 15, 0, 0, 0, 0);
        settle();
        check("line15_word0", int'(data_out), 16'h0000);
        check("line15_dirty", int'(dirty), 1);
        do_op(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        settle();

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL queue_drain got %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
